seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 55 +++++
 rtl/seg7_scan_driver_if.sv | 29 ++
 rtl/seg7_glyph_decode.sv | 17 +
 rtl/seg7_scan_driver.sv | 110 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks.
//   seg_t       : logical segment pattern {a,b,c,d,e,f,g}, 1 = lit, bit 6 = a
//   SEG_0..F    : glyph constants, SEG_BLANK = all segments off
//   seg7_glyph  : nibble + hex/BCD mode -> logical pattern
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Logical glyph; in BCD mode the non-decimal codes 10..15 show blank.
    function automatic seg_t seg7_glyph(input logic [3:0] nibble, input logic mode_hex);
        seg_t g;
        case (nibble)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            4'hF:    g = SEG_F;
            default: g = SEG_BLANK;
        endcase
        if (!mode_hex && (nibble > 4'd9)) begin
            g = SEG_BLANK;
        end
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between a datapath producer and the multiplexed display driver.
//   master : drives load/data_in/dp_in/mode_hex/blank_lz, observes pins
//   slave  : the driver; consumes the value bus, drives seg/dp/dig_en
interface seg7_scan_driver_if
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) ();

    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      mode_hex;
    logic                      blank_lz;
    seg_t                      seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     dig_en;

    modport master (
        output load, data_in, dp_in, mode_hex, blank_lz,
        input  seg, dp, dig_en
    );

    modport slave (
        input  load, data_in, dp_in, mode_hex, blank_lz,
        output seg, dp, dig_en
    );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational single-digit decoder: nibble + mode -> logical segments.
//   nibble   : 4-bit value to show
//   mode_hex : 1 = hex glyphs for 10..15, 0 = BCD (10..15 blank)
//   seg_c    : logical pattern {a..g}, 1 = lit
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       mode_hex,
    output seg_t       seg_c
);

    always_comb begin
        seg_c = seg7_glyph(nibble, mode_hex);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit time-multiplexed 7-segment driver.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seg7_scan_driver_if
//              load/data_in/dp_in  -> shadowed on load
//              mode_hex/blank_lz   -> sampled live every edge
//              seg/dp/dig_en       -> registered pins, polarity applied
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIV            = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam seg_t                  SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [NUM_DIGITS-1:0][3:0] shadow_q,    shadow_d;
    logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
    logic [PRE_W-1:0]           pre_q,       pre_d;
    logic [IDX_W-1:0]           idx_q,       idx_d;
    seg_t                       seg_q,       seg_d;
    logic                       dp_q,        dp_d;
    logic [NUM_DIGITS-1:0]      dig_en_q,    dig_en_d;

    logic [3:0]                 cur_nib_c;
    seg_t                       glyph_c;
    logic [NUM_DIGITS-1:0]      hi_zero_c;
    logic                       run_zero_c;
    logic                       blank_c;

    // Shadow capture, prescaler and digit index.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pre_d       = pre_q + PRE_W'(1);
        idx_d       = idx_q;
        if (bus.load) begin
            shadow_d    = bus.data_in;
            shadow_dp_d = bus.dp_in;
        end
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign cur_nib_c = shadow_q[idx_q];

    seg7_glyph_decode u_glyph (
        .nibble   (cur_nib_c),
        .mode_hex (bus.mode_hex),
        .seg_c    (glyph_c)
    );

    // hi_zero_c[i] = nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        hi_zero_c  = '0;
        run_zero_c = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            run_zero_c   = run_zero_c & (shadow_q[i] == 4'h0);
            hi_zero_c[i] = run_zero_c;
        end
    end

    // Digit 0 is exempt so an all-zero value still shows one "0".
    assign blank_c = bus.blank_lz && (idx_q != '0) && hi_zero_c[idx_q];

    // Next pin values from the index/shadow held before this edge.
    always_comb begin
        seg_d    = (blank_c ? SEG_BLANK : glyph_c) ^ SEG_OFF;
        dp_d     = shadow_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
        dig_en_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pre_q       <= '0;
            idx_q       <= '0;
            seg_q       <= SEG_OFF;
            dp_q        <= SEG_ACTIVE_LOW;
            dig_en_q    <= DIG_OFF;
        end else begin
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            dig_en_q    <= dig_en_d;
        end
    end

    assign bus.seg    = seg_q;
    assign bus.dp     = dp_q;
    assign bus.dig_en = dig_en_q;

endmodule
